// File: rtl/slt_share_arbiter.sv
// slt_share_arbiter: round-robin arbiter sharing one signed less-than comparator among NREQ requesters.
// Revision 1.0 - initial release.
`default_nettype none

module slt_share_arbiter #(
  parameter  int WIDTH = 3,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_lt,
  output logic [IDW-1:0]        rsp_id
);

  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          grant_id;
  logic                    grant_found;
  logic [IDW:0]            scan_sum;
  logic [IDW-1:0]          scan_idx;
  logic                    can_accept;
  logic                    accept;
  logic signed [WIDTH-1:0] op0;
  logic signed [WIDTH-1:0] op1;
  logic                    cmp_lt;
  logic [IDW-1:0]          ptr_next;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = grant_found && can_accept;

  always_comb begin
    req_ready = '0;
    if (accept && ASYNCRESETN) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign op0    = req_in0[grant_id*WIDTH +: WIDTH];
  assign op1    = req_in1[grant_id*WIDTH +: WIDTH];
  assign cmp_lt = (op0 < op1);

  assign ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);

  // A grant reloads the slot even while it drains, so streaming has no bubble.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rsp_valid <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_lt    <= cmp_lt;
      rsp_id    <= grant_id;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slt_share_arbiter.sv
// tb_slt_share_arbiter: directed self-checking bench for slt_share_arbiter.
`default_nettype none

module tb_slt_share_arbiter;
  localparam int W = 3;
  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_in0;
  logic [N*W-1:0] req_in1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_lt;
  logic [1:0]   rsp_id;

  int tests;
  int fails;

  slt_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .CLK        (clk),
    .ASYNCRESETN(rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lt     (rsp_lt),
    .rsp_id     (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_pair(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  function automatic logic ref_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    int va;
    int vb;
    va = a[W-1] ? int'(a) - (1 << W) : int'(a);
    vb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    return va < vb;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_lt !== 1'b0) begin fails++; $display("FAIL reset_rsp_lt: got %b want 0", rsp_lt); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_valid: got %b want 0", rsp_valid); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    set_pair(1, 3'b100, 3'b011);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    tests++; if (rsp_lt !== 1'b1) begin fails++; $display("FAIL single_lt: got %b want 1", rsp_lt); end
    tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL single_id: got %0d want 1", rsp_id); end
  endtask

  task automatic test_signed();
    logic [W-1:0] ca [3];
    logic [W-1:0] cb [3];
    logic         ce [3];
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         exp_lt;
    ca[0] = 3'b011; cb[0] = 3'b100; ce[0] = 1'b0;
    ca[1] = 3'b111; cb[1] = 3'b000; ce[1] = 1'b1;
    ca[2] = 3'b101; cb[2] = 3'b101; ce[2] = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int t = 0; t < 3 + 64; t++) begin
      if (t < 3) begin
        a = ca[t]; b = cb[t]; exp_lt = ce[t];
      end else begin
        a = W'((t - 3) >> W); b = W'(t - 3); exp_lt = ref_lt(a, b);
      end
      set_pair(0, a, b);
      #1;
      @(posedge clk);
      #1;
      tests++;
      if (rsp_lt !== exp_lt || rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
        fails++;
        $display("FAIL signed_cmp %b<%b: got lt=%b id=%0d v=%b want lt=%b id=0 v=1", a, b, rsp_lt, rsp_id, rsp_valid, exp_lt);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic exp_lt [4];
    do_reset();
    set_pair(0, 3'b000, 3'b001); exp_lt[0] = 1'b1;
    set_pair(1, 3'b001, 3'b000); exp_lt[1] = 1'b0;
    set_pair(2, 3'b100, 3'b101); exp_lt[2] = 1'b1;
    set_pair(3, 3'b011, 3'b111); exp_lt[3] = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        fails++; $display("FAIL rr_ready step %0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      @(posedge clk);
      #1;
      tests++;
      if (rsp_id !== 2'(k % 4) || rsp_valid !== 1'b1 || rsp_lt !== exp_lt[k % 4]) begin
        fails++;
        $display("FAIL rr_rsp step %0d: got id=%0d v=%b lt=%b want id=%0d v=1 lt=%b", k, rsp_id, rsp_valid, rsp_lt, k % 4, exp_lt[k % 4]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_pair(2, 3'b001, 3'b010);
    set_pair(3, 3'b010, 3'b001);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready cycle %0d: got %b want 0000", k, req_ready); end
      @(posedge clk);
      #1;
      tests++;
      if (rsp_id !== 2'd2 || rsp_valid !== 1'b1 || rsp_lt !== 1'b1) begin
        fails++; $display("FAIL bp_hold cycle %0d: got id=%0d v=%b lt=%b want id=2 v=1 lt=1", k, rsp_id, rsp_valid, rsp_lt);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
    @(posedge clk);
    #1;
    tests++;
    if (rsp_id !== 2'd3 || rsp_valid !== 1'b1 || rsp_lt !== 1'b0) begin
      fails++; $display("FAIL bp_release_rsp: got id=%0d v=%b lt=%b want id=3 v=1 lt=0", rsp_id, rsp_valid, rsp_lt);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_pair(1, 3'b110, 3'b010);
    set_pair(3, 3'b000, 3'b000);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin fails++; $display("FAIL mid_prefill: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id); end
    #2 rst_n = 1'b0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_clear: got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
    @(posedge clk);
    #1;
    tests++;
    if (rsp_id !== 2'd1 || rsp_valid !== 1'b1 || rsp_lt !== 1'b1) begin
      fails++; $display("FAIL mid_rsp: got id=%0d v=%b lt=%b want id=1 v=1 lt=1", rsp_id, rsp_valid, rsp_lt);
    end
    req_valid = '0;
  endtask

  task automatic test_drain();
    do_reset();
    set_pair(2, 3'b110, 3'b001);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req_valid = '0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_lt !== 1'b1 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL drain_first: got v=%b lt=%b id=%0d want v=1 lt=1 id=2", rsp_valid, rsp_lt, rsp_id);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || rsp_lt !== 1'b1 || rsp_id !== 2'd2) begin
        fails++; $display("FAIL drain_idle cycle %0d: got v=%b lt=%b id=%0d want v=0 lt=1 id=2", k, rsp_valid, rsp_lt, rsp_id);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_in0   = '0;
    req_in1   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slt_share_arbiter.md
Name: slt_share_arbiter

Overview:
- Shares one signed less-than comparator between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The comparator result and the winning requester ID are registered into a single-entry response slot with its own valid/ready handshake.
- Sits between client blocks needing occasional SInt comparisons and the shared comparator datapath. Saves replicating the comparator.

Parameters:
- WIDTH, 3, operand width in bits; operands are two's-complement signed.
- NREQ, 4, number of requesters; must be at least 2.
- IDW, $clog2(NREQ), width of the requester ID field (derived, not overridden).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair pending.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle. One-hot or zero.
- req_in0  input  NREQ*WIDTH  requester i's left operand at bits [i*WIDTH +: WIDTH].
- req_in1  input  NREQ*WIDTH  requester i's right operand at bits [i*WIDTH +: WIDTH].
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_lt  output  1  registered result: $signed(in0) < $signed(in1).
- rsp_id  output  IDW  index of the requester that produced rsp_lt.

Behaviour:
- Reset (ASYNCRESETN low, takes effect immediately, independent of CLK):
  - rsp_valid=0, rsp_lt=0, rsp_id=0.
  - Priority pointer ptr=0.
  - req_ready=0 while reset is asserted.
- Slot state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = EMPTY or (FULL and rsp_ready).
- Arbitration (combinational):
  - Scan req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit is the grant g.
  - req_ready[g]=1 only when can_accept; all other bits 0.
  - No valid requests means no grant and req_ready=0.
- On a grant at a rising edge:
  - rsp_lt <= signed compare of req_in0[g] and req_in1[g].
  - rsp_id <= g.
  - rsp_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- Latency: result visible on rsp_* one cycle after the accepting edge.
- Throughput: one comparison per cycle when rsp_ready is held high.
- Response handshake with no new grant in the same cycle: rsp_valid <= 0. rsp_lt and rsp_id hold their last values.
- Simultaneous response handshake and grant: the slot is reloaded with the new result and rsp_valid stays 1. There is no bubble.
- Backpressure: while FULL and rsp_ready=0:
  - req_ready=0.
  - rsp_lt, rsp_id and rsp_valid are stable.
  - ptr is unchanged.
- Requesters may assert req_valid at any time. A request is consumed only on a cycle where its req_ready=1.
- Requester obligation: hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is legal. No state is kept per requester.
- Compare rule:
  - Full WIDTH-bit two's-complement; the MSB is the sign.
  - Equal operands give 0.
  - The most negative value (-2^(WIDTH-1)) is less than every other value.
- Fairness: a continuously asserted requester is granted within NREQ accepting cycles.
- Reset mid-operation:
  - Any held response is discarded (rsp_valid=0).
  - ptr returns to 0.
  - Requests pending at reset release are arbitrated fresh from index 0.

Test Plan:
1. Single request, NREQ=4, WIDTH=3: req_valid=4'b0010, in0=3'b100 (-4), in1=3'b011 (3), rsp_ready=1 -> req_ready=4'b0010 that cycle; next cycle rsp_valid=1, rsp_lt=1, rsp_id=1.
2. Signed corner cases on requester 0:
   - 3'b011 vs 3'b100 -> rsp_lt=0.
   - 3'b111 (-1) vs 3'b000 -> rsp_lt=1.
   - 3'b101 vs 3'b101 -> rsp_lt=0.
   - Sweep all 64 operand pairs and check against a signed reference model.
3. Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id sequence 0,1,2,3,0 on consecutive cycles; rsp_valid high throughout after the first cycle.
4. Backpressure: fill the slot from requester 2, hold rsp_ready=0 for 5 cycles with req_valid=4'b1111 -> req_ready=0 and rsp_id=2 stable for all 5 cycles; raise rsp_ready -> requester 3 is granted that same cycle and rsp_id=3 the next cycle with no bubble.
5. Reset mid-operation: slot FULL with rsp_id=3 and ptr=0b00 after wrap; pulse ASYNCRESETN low between clock edges -> rsp_valid falls immediately; after release with req_valid=4'b1010, the first grant is requester 1.
6. Idle and drain: a single request accepted, then req_valid=0 and rsp_ready=1 -> rsp_valid=1 for exactly one cycle then 0; rsp_lt and rsp_id retain their values.
